// File: rtl/sched_pkg.sv
// Shared types for the command scheduler: the radar command record and the scheduler states.
package sched_pkg;

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] delta_freq;
    logic [31:0] delta_rate;
    logic [47:0] time_start;
    logic [15:0] n_impuls;
    logic [1:0]  type_imp;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_RUN
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with flop-based storage, so the head entry comes straight from registers.
// Level/empty/full are registered and update the cycle after a push or pop.
module cmd_fifo
  import sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = CMD_W
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLvl = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  // A clear wins over both a concurrent push and pop.
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !RESET) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign empty = (level_q == '0);
  assign full  = (level_q == FullLvl);

endmodule

// File: rtl/cmd_scheduler.sv
// Timed command queue feeding the pulse-train executor; drops and counts late commands.
// Optional SCHED_FLUSH_EN adds a FLUSH input that discards all queued, not-yet-loaded commands.
module cmd_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LEAD   = 125,
  parameter int unsigned MARGIN = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [63:0]            TIME_NOW,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [CMD_W-1:0]       CMD_IN,
  input  logic                   EXEC_DONE,
`ifdef SCHED_FLUSH_EN
  input  logic                   FLUSH,
`endif
  output logic                   WR_DATA,
  output logic [CMD_W-1:0]       CMD_OUT,
  output logic                   LATE,
  output logic [15:0]            LATE_CNT,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   EMPTY,
  output logic                   FULL
);

  // The load decision is taken in S_WAIT one cycle before S_LOAD drives WR_DATA,
  // so the threshold is LEAD+1 to land the strobe exactly LEAD cycles before time_start.
  localparam logic [47:0] MarginW = 48'(MARGIN);
  localparam logic [47:0] LoadW   = 48'(LEAD + 1);

  state_e           state_q, state_d;
  logic [CMD_W-1:0] head_bits;
  cmd_t             head_cmd;
  logic [CMD_W-1:0] cmd_out_q;
  logic [15:0]      late_cnt_q;
  logic             fifo_empty, fifo_full;
  logic             pop, late, load;
  logic             flush;
  logic [47:0]      diff;
  logic             is_late, is_due;
  logic             unused_time;

`ifdef SCHED_FLUSH_EN
  assign flush = FLUSH;
`else
  assign flush = 1'b0;
`endif

  assign unused_time = ^TIME_NOW[63:48];

  cmd_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(CMD_W)
  ) u_fifo (
    .CLK  (CLK),
    .RESET(RESET),
    .clear(flush),
    .push (CMD_VALID),
    .pop  (pop),
    .wdata(CMD_IN),
    .head (head_bits),
    .level(LEVEL),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign head_cmd = cmd_t'(head_bits);

  // Modulo-2^48 difference read as signed handles time wrap-around.
  assign diff    = head_cmd.time_start - TIME_NOW[47:0];
  assign is_late = $signed(diff) <= $signed(MarginW);
  assign is_due  = $signed(diff) <= $signed(LoadW);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    late    = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !flush) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush || fifo_empty) begin
          state_d = S_IDLE;
        end else if (is_late) begin
          pop     = 1'b1;
          late    = 1'b1;
          state_d = S_IDLE;
        end else if (is_due) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        pop     = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (EXEC_DONE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cmd_out_q  <= '0;
      late_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) cmd_out_q <= head_bits;
      if (late && late_cnt_q != 16'hFFFF) late_cnt_q <= late_cnt_q + 16'd1;
    end
  end

  // CMD_OUT shows the head combinationally during the load cycle so it is valid with WR_DATA.
  assign WR_DATA   = load;
  assign CMD_OUT   = load ? head_bits : cmd_out_q;
  assign LATE      = late;
  assign LATE_CNT  = late_cnt_q;
  assign EMPTY     = fifo_empty;
  assign FULL      = fifo_full;
  assign CMD_READY = !fifo_full;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed self-checking bench for cmd_scheduler: timing of loads, late drops, fill, wrap, reset.
module tb_cmd_scheduler;
  import sched_pkg::*;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [63:0]      TIME_NOW = '0;
  logic             CMD_VALID = 1'b0;
  logic             CMD_READY;
  logic [CMD_W-1:0] CMD_IN = '0;
  logic             EXEC_DONE = 1'b0;
`ifdef SCHED_FLUSH_EN
  logic             FLUSH = 1'b0;
`endif
  logic             WR_DATA;
  logic [CMD_W-1:0] CMD_OUT;
  logic             LATE;
  logic [15:0]      LATE_CNT;
  logic [3:0]       LEVEL;
  logic             EMPTY, FULL;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int late_count = 0;
  logic [47:0]      wr_time = '0;
  logic [CMD_W-1:0] wr_cmd = '0;

  cmd_scheduler #(
    .DEPTH (8),
    .LEAD  (125),
    .MARGIN(4)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .TIME_NOW (TIME_NOW),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_IN   (CMD_IN),
    .EXEC_DONE(EXEC_DONE),
`ifdef SCHED_FLUSH_EN
    .FLUSH    (FLUSH),
`endif
    .WR_DATA  (WR_DATA),
    .CMD_OUT  (CMD_OUT),
    .LATE     (LATE),
    .LATE_CNT (LATE_CNT),
    .LEVEL    (LEVEL),
    .EMPTY    (EMPTY),
    .FULL     (FULL)
  );

  always #4 CLK = ~CLK;

  // Record load strobes and late pulses mid-cycle.
  always @(negedge CLK) begin
    if (WR_DATA) begin
      wr_count = wr_count + 1;
      wr_time  = TIME_NOW[47:0];
      wr_cmd   = CMD_OUT;
    end
    if (LATE) late_count = late_count + 1;
  end

  task automatic check(input string tag, input logic [CMD_W-1:0] act, input logic [CMD_W-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: inputs change 1 time unit after the edge, time advances one tick per cycle.
  task automatic step();
    @(posedge CLK);
    #1;
    TIME_NOW = TIME_NOW + 64'd1;
  endtask

  function automatic cmd_t mk(input int id, input logic [47:0] ts);
    cmd_t c;
    c.freq       = 48'h1000 + 48'(id);
    c.delta_freq = 48'h2000 + 48'(id);
    c.delta_rate = 32'h300 + 32'(id);
    c.time_start = ts;
    c.n_impuls   = 16'(id + 1);
    c.type_imp   = 2'(id);
    c.ti         = 32'h40 + 32'(id);
    c.tp         = 32'h50 + 32'(id);
    c.tblank1    = 32'h60 + 32'(id);
    c.tblank2    = 32'h70 + 32'(id);
    return c;
  endfunction

  task automatic push(input cmd_t c);
    CMD_VALID = 1'b1;
    CMD_IN    = c;
    step();
    CMD_VALID = 1'b0;
  endtask

  task automatic exec_done();
    EXEC_DONE = 1'b1;
    step();
    EXEC_DONE = 1'b0;
  endtask

  task automatic wait_wr(input string tag, input int target, input int budget);
    int n = 0;
    while (wr_count < target && n < budget) begin
      step();
      n++;
    end
    check(tag, CMD_W'(wr_count), CMD_W'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"}, CMD_W'(WR_DATA), CMD_W'(0));
    check({tag, "_late"}, CMD_W'(LATE), CMD_W'(0));
    check({tag, "_late_cnt"}, CMD_W'(LATE_CNT), CMD_W'(0));
    check({tag, "_cmd_out"}, CMD_OUT, CMD_W'(0));
    check({tag, "_level"}, CMD_W'(LEVEL), CMD_W'(0));
    check({tag, "_empty"}, CMD_W'(EMPTY), CMD_W'(1));
    check({tag, "_full"}, CMD_W'(FULL), CMD_W'(0));
    check({tag, "_ready"}, CMD_W'(CMD_READY), CMD_W'(1));
  endtask

  initial begin
    cmd_t        c;
    logic [47:0] t0;
    int          lc;

    step();
    step();
    RESET = 1'b0;
    check_reset_outputs("rst");

    // Single command: strobe exactly LEAD cycles before time_start.
    TIME_NOW = 64'd1000;
    c = mk(1, 48'd2000);
    push(c);
    wait_wr("t1_wr", 1, 2000);
    check("t1_time", CMD_W'(wr_time), CMD_W'(1875));
    check("t1_cmd", wr_cmd, c);
    check("t1_no_late", CMD_W'(late_count), CMD_W'(0));
    exec_done();
    step();
    check("t1_empty", CMD_W'(EMPTY), CMD_W'(1));

    // Late command: dropped, counted, never loaded.
    c = mk(2, TIME_NOW[47:0] + 48'd2);
    push(c);
    lc = 0;
    while (late_count < 1 && lc < 20) begin
      step();
      lc++;
    end
    check("t2_late_pulses", CMD_W'(late_count), CMD_W'(1));
    check("t2_late_cnt", CMD_W'(LATE_CNT), CMD_W'(1));
    check("t2_no_wr", CMD_W'(wr_count), CMD_W'(1));
    check("t2_empty", CMD_W'(EMPTY), CMD_W'(1));

    // Fill to DEPTH, 9th push ignored, strict FIFO issue gated by EXEC_DONE.
    t0 = TIME_NOW[47:0] + 48'd300;
    for (int i = 0; i < 8; i++) push(mk(10 + i, t0));
    check("t3_full", CMD_W'(FULL), CMD_W'(1));
    check("t3_ready", CMD_W'(CMD_READY), CMD_W'(0));
    check("t3_level8", CMD_W'(LEVEL), CMD_W'(8));
    push(mk(99, t0));
    check("t3_level_after_9th", CMD_W'(LEVEL), CMD_W'(8));
    for (int i = 0; i < 8; i++) begin
      wait_wr("t3_wr", 2 + i, 400);
      check("t3_cmd", wr_cmd, mk(10 + i, t0));
      check("t3_level", CMD_W'(LEVEL), CMD_W'(7 - i));
      repeat (5) step();
      check("t3_hold_until_done", CMD_W'(wr_count), CMD_W'(2 + i));
      exec_done();
    end
    repeat (10) step();
    check("t3_no_9th", CMD_W'(wr_count), CMD_W'(9));
    check("t3_empty", CMD_W'(EMPTY), CMD_W'(1));
    check("t3_no_late", CMD_W'(late_count), CMD_W'(1));

    // Wrap of the 48-bit time; upper TIME_NOW bits must be ignored.
    TIME_NOW = {16'hABCD, 48'hFFFF_FFFF_FFCE};
    c = mk(3, 48'd100);
    push(c);
    wait_wr("t4_wr", 10, 400);
    check("t4_time", CMD_W'(wr_time), CMD_W'(48'hFFFF_FFFF_FFE7));
    check("t4_cmd", wr_cmd, c);
    check("t4_no_late", CMD_W'(late_count), CMD_W'(1));
    exec_done();

    // Reset while running with three queued.
    t0 = TIME_NOW[47:0] + 48'd200;
    for (int i = 0; i < 4; i++) push(mk(20 + i, t0));
    wait_wr("t5_wr", 11, 400);
    check("t5_level3", CMD_W'(LEVEL), CMD_W'(3));
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check_reset_outputs("t5_rst");
    exec_done();
    repeat (300) step();
    check("t5_no_wr", CMD_W'(wr_count), CMD_W'(11));

`ifdef SCHED_FLUSH_EN
    // Flush while running: queue cleared, running command still waits for EXEC_DONE.
    t0 = TIME_NOW[47:0] + 48'd200;
    for (int i = 0; i < 5; i++) push(mk(30 + i, t0));
    wait_wr("t6_wr", 12, 400);
    check("t6_level4", CMD_W'(LEVEL), CMD_W'(4));
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    check("t6_level0", CMD_W'(LEVEL), CMD_W'(0));
    check("t6_empty", CMD_W'(EMPTY), CMD_W'(1));
    exec_done();
    repeat (300) step();
    check("t6_no_wr", CMD_W'(wr_count), CMD_W'(12));
    check("t6_late_cnt", CMD_W'(LATE_CNT), CMD_W'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
